// File: rtl/log10_arbiter_if.sv
// Bundle of requester, response and shared-Log10 signals around log10_arbiter.
// The arbiter connects through the slave modport; its environment uses master.
interface log10_arbiter_if #(
  parameter int NREQ = 4,
  parameter int WI   = 10,
  parameter int WF   = 40,
  parameter int WIO  = 12,
  parameter int WFO  = 12
);
  localparam int OPW = WI + WF;
  localparam int RW  = WIO + WFO;
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ*OPW-1:0] req_data;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [RW-1:0]       rsp_data;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_err;
  logic [OPW-1:0]      log_in;
  logic                log_rst;
  logic [RW-1:0]       log_out;
  logic                log_negflow;

  modport slave (
    input  req_valid, req_data, rsp_ready, log_out, log_negflow,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, log_in, log_rst
  );

  modport master (
    output req_valid, req_data, rsp_ready, log_out, log_negflow,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, log_in, log_rst
  );
endinterface

// File: rtl/log10_arbiter.sv
// Round-robin arbiter time-sharing one combinational Log10 unit among NREQ requesters;
// one operand in flight at a time, result returned with its requester id.
module log10_arbiter #(
  parameter int NREQ = 4,
  parameter int WI   = 10,
  parameter int WF   = 40,
  parameter int WIO  = 12,
  parameter int WFO  = 12,
  parameter int LAT  = 2
) (
  input  logic Clk,
  input  logic Rst,
  log10_arbiter_if.slave bus
);
  localparam int OPW = WI + WF;
  localparam int RW  = WIO + WFO;
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]     r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_id;
  logic [CW-1:0]  r_cnt;
  logic [OPW-1:0] r_log_in;
  logic           r_rsp_valid;
  logic [RW-1:0]  r_rsp_data;
  logic [IDW-1:0] r_rsp_id;
  logic           r_rsp_err;

  logic [OPW-1:0]  w_ops [NREQ];
  logic            w_found;
  logic            w_hit;
  logic [IDW:0]    w_sum;
  logic [IDW-1:0]  w_idx;
  logic [IDW-1:0]  w_gidx;
  logic [IDW-1:0]  w_next_ptr;
  logic [NREQ-1:0] w_req_ready;
  logic            w_err;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
    assign w_ops[gi] = bus.req_data[gi*OPW +: OPW];
  end

  // Round-robin pick: scan downward through the search order so the last hit is the first from rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_sum   = '0;
    w_idx   = '0;
    w_hit   = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_sum   = {1'b0, r_rr_ptr} + (IDW+1)'(i);
      w_idx   = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ)) : IDW'(w_sum);
      w_hit   = bus.req_valid[w_idx];
      w_found = w_found | w_hit;
      w_gidx  = w_hit ? w_idx : w_gidx;
    end
  end

  assign w_next_ptr = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + IDW'(1);
  // A zero operand cannot be caught by the unit's flag, so it is tested here.
  assign w_err      = bus.log_negflow | r_log_in[OPW-1] | (r_log_in == '0);

  // One-hot accept strobe, only while idle.
  always_comb begin
    w_req_ready = '0;
    if ((r_state == S_IDLE) && w_found) begin
      w_req_ready[w_gidx] = 1'b1;
    end else begin
      w_req_ready = '0;
    end
  end

  // Grant / settle / respond state machine.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_log_in    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_log_in <= w_ops[w_gidx];
            r_id     <= w_gidx;
            r_rr_ptr <= w_next_ptr;
            r_cnt    <= '0;
            r_state  <= S_EVAL;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_EVAL: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(LAT - 1)) begin
            r_rsp_data  <= w_err ? '0 : bus.log_out;
            r_rsp_err   <= w_err;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_state     <= S_EVAL;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state     <= S_RESP;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.log_in    = r_log_in;
  // The shared unit is held in reset exactly as long as this block is.
  assign bus.log_rst   = Rst;
endmodule

// File: tb/tb_log10_arbiter.sv
// Directed bench for log10_arbiter with a behavioural Log10 unit on the shared-unit pins.
module tb_log10_arbiter;
  localparam logic [49:0] OP_0    = 50'h0;
  localparam logic [49:0] OP_1    = 50'h10000000000;
  localparam logic [49:0] OP_2    = 50'h20000000000;
  localparam logic [49:0] OP_3    = 50'h30000000000;
  localparam logic [49:0] OP_10   = 50'hA0000000000;
  localparam logic [49:0] OP_100  = 50'h640000000000;
  localparam logic [49:0] OP_NEG5 = 50'h3FB0000000000;

  logic Clk = 1'b0;
  logic Rst;
  logic force_nf;
  logic [49:0] tb_ops [4];
  int n_vec = 0;
  int n_err = 0;
  real m_x;
  real m_v;

  log10_arbiter_if #(.NREQ(4), .WI(10), .WF(40), .WIO(12), .WFO(12)) bus ();

  log10_arbiter #(.NREQ(4), .WI(10), .WF(40), .WIO(12), .WFO(12), .LAT(2)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_pack
    assign bus.req_data[gi*50 +: 50] = tb_ops[gi];
  end

  // Shared Log10 unit: rounded Q12.12; garbage for non-positive input, flag only on demand.
  always_comb begin
    m_x = real'($signed(bus.log_in)) / 1099511627776.0;
    if (m_x > 0.0) begin
      m_v = $log10(m_x) * 4096.0;
      bus.log_out = 24'($rtoi($floor(m_v + 0.5)));
    end else begin
      m_v = 0.0;
      bus.log_out = 24'hABCDEF;
    end
    bus.log_negflow = force_nf;
  end

  task automatic send_one(input logic [1:0] id, input logic [49:0] op, output int lat,
                          output int pulses, output logic [23:0] d, output logic [1:0] rid,
                          output logic e);
    int  gcyc;
    bit  drop;
    lat = -1; pulses = 0; gcyc = 0; drop = 1'b0; d = '0; rid = '0; e = 1'b0;
    @(negedge Clk);
    tb_ops[id] = op;
    bus.req_valid[id] = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (bus.req_ready != 4'b0000) begin pulses++; gcyc = c; drop = 1'b1; end
      if (bus.rsp_valid) begin
        d = bus.rsp_data; rid = bus.rsp_id; e = bus.rsp_err; lat = c - gcyc;
        break;
      end
      @(negedge Clk);
      if (drop) begin bus.req_valid[id] = 1'b0; drop = 1'b0; end
    end
    bus.req_valid = 4'b0000;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    #1;
    n_vec++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_req_ready: got %b want 0000", bus.req_ready); end
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_vec++; if (bus.rsp_data !== 24'h0) begin n_err++; $display("FAIL rst_rsp_data: got %h want 0", bus.rsp_data); end
    n_vec++; if ((bus.rsp_id !== 2'd0) || (bus.rsp_err !== 1'b0)) begin n_err++; $display("FAIL rst_id_err: got %0d/%b want 0/0", bus.rsp_id, bus.rsp_err); end
    n_vec++; if (bus.log_in !== 50'h0) begin n_err++; $display("FAIL rst_log_in: got %h want 0", bus.log_in); end
    n_vec++; if (bus.log_rst !== 1'b0) begin n_err++; $display("FAIL rst_log_rst_low: got %b want 0", bus.log_rst); end
    Rst = 1'b1;
    #1;
    n_vec++; if (bus.log_rst !== 1'b1) begin n_err++; $display("FAIL rst_log_rst_high: got %b want 1", bus.log_rst); end
  endtask

  task automatic test_single();
    int lat, pulses, diff;
    logic [23:0] d; logic [1:0] rid; logic e;
    send_one(2'd0, OP_100, lat, pulses, d, rid, e);
    diff = int'($signed(d)) - 32'sh2000;
    n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL single_pulses: got %0d want 1", pulses); end
    // Cycles from the req_ready cycle to the first rsp_valid cycle: LAT+1.
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL single_latency: got %0d want 3", lat); end
    n_vec++; if ((diff > 2) || (diff < -2)) begin n_err++; $display("FAIL single_data: got %h want 002000", d); end
    n_vec++; if ((rid !== 2'd0) || (e !== 1'b0)) begin n_err++; $display("FAIL single_id_err: got %0d/%b want 0/0", rid, e); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  ids [4];
    logic [23:0] ds  [4];
    logic [23:0] want [4];
    int cyc [4];
    int n, diff;
    logic [3:0] drop;
    want[0] = 24'h000000; want[1] = 24'h001000; want[2] = 24'h002000; want[3] = 24'h0004D1;
    n = 0; drop = 4'b0000;
    for (int k = 0; k < 4; k++) begin ids[k] = 2'd0; ds[k] = 24'h0; cyc[k] = 0; end
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    tb_ops[0] = OP_1; tb_ops[1] = OP_10; tb_ops[2] = OP_100; tb_ops[3] = OP_2;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int c = 0; (c < 60) && (n < 4); c++) begin
      #1;
      if (bus.req_ready != 4'b0000) drop = bus.req_ready;
      if (bus.rsp_valid) begin ids[n] = bus.rsp_id; ds[n] = bus.rsp_data; cyc[n] = c; n++; end
      @(negedge Clk);
      bus.req_valid = bus.req_valid & ~drop;
      drop = 4'b0000;
    end
    n_vec++; if (n !== 4) begin n_err++; $display("FAIL rr_count: got %0d want 4", n); end
    for (int k = 0; k < 4; k++) begin
      diff = int'($signed(ds[k])) - int'($signed(want[k]));
      n_vec++; if (ids[k] !== 2'(k)) begin n_err++; $display("FAIL rr_id%0d: got %0d want %0d", k, ids[k], k); end
      n_vec++; if ((diff > 2) || (diff < -2)) begin n_err++; $display("FAIL rr_data%0d: got %h want %h", k, ds[k], want[k]); end
    end
    n_vec++; if ((cyc[1] - cyc[0]) !== 4) begin n_err++; $display("FAIL rr_throughput: got %0d want 4", cyc[1] - cyc[0]); end
    bus.req_valid = 4'b1111;
    #1;
    n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL rr_wrap: got %b want 0001", bus.req_ready); end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_error();
    int lat, pulses;
    logic [23:0] d; logic [1:0] rid; logic e;
    send_one(2'd1, OP_0, lat, pulses, d, rid, e);
    n_vec++; if ((e !== 1'b1) || (d !== 24'h0) || (rid !== 2'd1)) begin n_err++; $display("FAIL err_zero: got err=%b data=%h id=%0d want 1/000000/1", e, d, rid); end
    send_one(2'd3, OP_NEG5, lat, pulses, d, rid, e);
    n_vec++; if ((e !== 1'b1) || (d !== 24'h0) || (rid !== 2'd3)) begin n_err++; $display("FAIL err_neg: got err=%b data=%h id=%0d want 1/000000/3", e, d, rid); end
    force_nf = 1'b1;
    send_one(2'd2, OP_3, lat, pulses, d, rid, e);
    force_nf = 1'b0;
    n_vec++; if ((e !== 1'b1) || (d !== 24'h0) || (rid !== 2'd2)) begin n_err++; $display("FAIL err_negflow: got err=%b data=%h id=%0d want 1/000000/2", e, d, rid); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] d0; logic [1:0] id0; logic e0;
    bit got; int diff;
    @(negedge Clk);
    tb_ops[0] = OP_10; tb_ops[1] = OP_100;
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1; if (bus.req_ready[0]) begin got = 1'b1; break; end
      @(negedge Clk);
    end
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL bp_grant0: got %b want 1", got); end
    @(negedge Clk);
    bus.req_valid = 4'b0010;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1; if (bus.rsp_valid) begin got = 1'b1; break; end
      @(negedge Clk);
    end
    d0 = bus.rsp_data; id0 = bus.rsp_id; e0 = bus.rsp_err;
    diff = int'($signed(d0)) - 32'sh1000;
    n_vec++; if ((got !== 1'b1) || (id0 !== 2'd0) || (e0 !== 1'b0) || (diff > 2) || (diff < -2)) begin
      n_err++; $display("FAIL bp_rsp0: got valid=%b id=%0d err=%b data=%h want 1/0/0/001000", got, id0, e0, d0);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk); #1;
      n_vec++;
      if ((bus.rsp_valid !== 1'b1) || (bus.rsp_data !== d0) || (bus.rsp_id !== id0) ||
          (bus.rsp_err !== e0) || (bus.req_ready !== 4'b0000)) begin
        n_err++; $display("FAIL bp_hold: cycle %0d got valid=%b data=%h id=%0d rdy=%b want 1/%h/%0d/0000", c, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready, d0, id0);
      end
    end
    @(negedge Clk);
    bus.rsp_ready = 1'b1;
    #1;
    n_vec++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_no_grant_in_resp: got %b want 0000", bus.req_ready); end
    @(negedge Clk); #1;
    n_vec++; if ((bus.rsp_valid !== 1'b0) || (bus.req_ready !== 4'b0010)) begin
      n_err++; $display("FAIL bp_grant1: got valid=%b rdy=%b want 0/0010", bus.rsp_valid, bus.req_ready);
    end
    @(negedge Clk);
    bus.req_valid = 4'b0000;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1; if (bus.rsp_valid) begin got = 1'b1; break; end
      @(negedge Clk);
    end
    diff = int'($signed(bus.rsp_data)) - 32'sh2000;
    n_vec++; if ((got !== 1'b1) || (bus.rsp_id !== 2'd1) || (diff > 2) || (diff < -2)) begin
      n_err++; $display("FAIL bp_rsp1: got valid=%b id=%0d data=%h want 1/1/002000", got, bus.rsp_id, bus.rsp_data);
    end
    @(negedge Clk);
  endtask

  task automatic test_withdrawal();
    bit got; int seen;
    logic [1:0] id0;
    @(negedge Clk);
    tb_ops[0] = OP_2;
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1; if (bus.req_ready[0]) break;
      @(negedge Clk);
    end
    @(negedge Clk);
    bus.req_valid = 4'b0000;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1; if (bus.rsp_valid) begin got = 1'b1; break; end
      @(negedge Clk);
    end
    id0 = bus.rsp_id;
    n_vec++; if ((got !== 1'b1) || (id0 !== 2'd0)) begin n_err++; $display("FAIL wd_rsp0: got valid=%b id=%0d want 1/0", got, id0); end
    seen = 0;
    @(negedge Clk);
    tb_ops[2] = OP_10;
    bus.req_valid = 4'b0100;
    #1; if (bus.req_ready != 4'b0000) seen++;
    @(negedge Clk); #1; if (bus.req_ready != 4'b0000) seen++;
    @(negedge Clk);
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b1;
    @(negedge Clk);
    for (int c = 0; c < 10; c++) begin
      #1; if ((bus.req_ready != 4'b0000) || bus.rsp_valid) seen++;
      @(negedge Clk);
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL wd_no_grant: got %0d grant/response cycles want 0", seen); end
  endtask

  task automatic test_reset_mid_eval();
    int seen;
    @(negedge Clk);
    tb_ops[1] = OP_10;
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1; if (bus.req_ready[1]) break;
      @(negedge Clk);
    end
    @(negedge Clk);
    bus.req_valid = 4'b0000;
    Rst = 1'b0;
    @(negedge Clk); #1;
    n_vec++; if ((bus.rsp_valid !== 1'b0) || (bus.rsp_data !== 24'h0) || (bus.rsp_id !== 2'd0) ||
                 (bus.rsp_err !== 1'b0) || (bus.log_in !== 50'h0) || (bus.req_ready !== 4'b0000)) begin
      n_err++; $display("FAIL mid_rst_outputs: got valid=%b data=%h id=%0d err=%b log_in=%h rdy=%b want all 0", bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err, bus.log_in, bus.req_ready);
    end
    n_vec++; if (bus.log_rst !== 1'b0) begin n_err++; $display("FAIL mid_rst_log_rst: got %b want 0", bus.log_rst); end
    Rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk); #1; if (bus.rsp_valid) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL mid_rst_no_rsp: got %0d want 0", seen); end
    bus.req_valid = 4'b1111;
    #1;
    n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_rst_rr_ptr: got %b want 0001", bus.req_ready); end
    bus.req_valid = 4'b0000;
  endtask

  initial begin
    Rst = 1'b0;
    force_nf = 1'b0;
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) tb_ops[k] = 50'h0;
    test_reset();
    test_single();
    test_round_robin();
    test_error();
    test_back_to_back();
    test_withdrawal();
    test_reset_mid_eval();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
